alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/tortoise_pkg.sv | 86 ++++++++
 rtl/age_matrix_sel.sv | 57 +++++
 rtl/alu_issue_queue.sv | 182 ++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tortoise_pkg.sv
// Shared types for the tortoise core: scoreboard entries, ALU opcodes and the issue-queue slot
// record, plus the operand-capture helper used at dispatch.
package tortoise_pkg;

    localparam int unsigned XLen    = 32;
    localparam int unsigned MaxTidW = 8;

    typedef logic [XLen-1:0] data_t;
    typedef logic [4:0]      reg_t;
    typedef logic [MaxTidW-1:0] tid_t;

    typedef enum logic [3:0] {
        FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR
    } fu_t;

    typedef enum logic [4:0] {
        ADD, SUB, XORL, ORL, ANDL, SLL, SRL, SRA, SLTS, SLTU,
        EQ, NE, LTS, LTU, GES, GEU, JAL_R
    } fu_op_t;

    typedef struct packed {
        data_t  pc;
        fu_t    fu;
        fu_op_t op;
        reg_t   rs1;
        reg_t   rs2;
        reg_t   rd;
        data_t  imm;
        logic   use_imm;
        logic   use_pc;
    } scoreboard_entry_t;

    typedef struct packed {
        logic  rdy;
        reg_t  rs;
        data_t val;
    } operand_t;

    typedef struct packed {
        logic     valid;
        fu_op_t   op;
        reg_t     rd;
        tid_t     id;
        operand_t opa;
        operand_t opb;
        data_t    opc;
    } slot_t;

    typedef struct packed {
        fu_op_t op;
        data_t  a;
        data_t  b;
        data_t  c;
        reg_t   rd;
        tid_t   id;
    } issue_t;

    // A busy register still counts as ready when its writer broadcasts in the same cycle.
    function automatic operand_t capture_operand(input logic  is_const,
                                                 input data_t const_val,
                                                 input reg_t  rs,
                                                 input logic  busy,
                                                 input data_t rf_data,
                                                 input logic  wb_valid,
                                                 input reg_t  wb_rd,
                                                 input data_t wb_data);
        operand_t o;
        o.rs  = rs;
        o.rdy = 1'b1;
        o.val = rf_data;
        if (is_const) begin
            o.val = const_val;
        end else if (rs == '0) begin
            o.val = '0;
        end else if (!busy) begin
            o.val = rf_data;
        end else if (wb_valid && (wb_rd == rs)) begin
            o.val = wb_data;
        end else begin
            o.rdy = 1'b0;
            o.val = '0;
        end
        return o;
    endfunction

endpackage

// File: rtl/age_matrix_sel.sv
// Oldest-first selector: tracks relative allocation order of slots in an age matrix and grants
// the oldest eligible slot.
module age_matrix_sel #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant
);

    // older_q[i][j] set means slot i was allocated before slot j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            older_d[i] = older_q[i];
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (free[i] || free[j]) begin
                    older_d[i][j] = 1'b0;
                end
                if (alloc[i]) begin
                    older_d[i][j] = 1'b0;
                end else if (alloc[j]) begin
                    older_d[i][j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (eligible[j] && older_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Out-of-order ALU issue queue: captures operands at dispatch, wakes them on result broadcast
// and issues the oldest ready entry through a single registered issue stage.
module alu_issue_queue
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TID_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              dispatch_valid_i,
    output logic              dispatch_ready_o,
    input  scoreboard_entry_t dispatch_sbe_i,
    input  logic [TID_W-1:0]  dispatch_id_i,
    input  logic              op1_busy_i,
    input  logic              op2_busy_i,
    input  data_t             op1_data_i,
    input  data_t             op2_data_i,
    input  logic              wb_valid_i,
    input  reg_t              wb_rd_i,
    input  data_t             wb_data_i,
    output logic              alu_valid_o,
    input  logic              alu_ready_i,
    output fu_op_t            alu_op_o,
    output data_t             alu_a_o,
    output data_t             alu_b_o,
    output data_t             alu_c_o,
    output reg_t              alu_rd_o,
    output logic [TID_W-1:0]  alu_id_o
);

    slot_t  slot_q [DEPTH];
    slot_t  slot_d [DEPTH];
    slot_t  new_slot;
    issue_t issue_q, issue_d, sel_issue;
    logic   issue_valid_q, issue_valid_d;

    logic [DEPTH-1:0] free_mask, alloc_oh, eligible, grant, issue_oh;
    logic             dispatch_fire, issue_take, issue_fire, wb_hit;

    assign wb_hit = wb_valid_i && (wb_rd_i != '0);

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            free_mask[i] = !slot_q[i].valid;
            eligible[i]  = slot_q[i].valid && slot_q[i].opa.rdy && slot_q[i].opb.rdy;
        end
    end

    assign dispatch_ready_o = |free_mask;
    assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o && !flush_i;

    // Descending scan so the lowest free index wins.
    always_comb begin
        alloc_oh = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
        if (!dispatch_fire) begin
            alloc_oh = '0;
        end
    end

    always_comb begin
        new_slot       = '0;
        new_slot.valid = 1'b1;
        new_slot.op    = dispatch_sbe_i.op;
        new_slot.rd    = dispatch_sbe_i.rd;
        new_slot.id    = MaxTidW'(dispatch_id_i);
        new_slot.opa   = capture_operand(dispatch_sbe_i.use_pc, dispatch_sbe_i.pc,
                                         dispatch_sbe_i.rs1, op1_busy_i, op1_data_i,
                                         wb_valid_i, wb_rd_i, wb_data_i);
        new_slot.opb   = capture_operand(dispatch_sbe_i.use_imm, dispatch_sbe_i.imm,
                                         dispatch_sbe_i.rs2, op2_busy_i, op2_data_i,
                                         wb_valid_i, wb_rd_i, wb_data_i);
        new_slot.opc   = (dispatch_sbe_i.op == JAL_R) ? dispatch_sbe_i.pc + data_t'(4) : '0;
    end

    age_matrix_sel #(
        .DEPTH(DEPTH)
    ) u_age_matrix_sel (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .alloc   (alloc_oh),
        .free    (issue_oh),
        .eligible(eligible),
        .grant   (grant)
    );

    assign issue_take = !issue_valid_q || alu_ready_i;
    assign issue_fire = issue_take && (|grant) && !flush_i;
    assign issue_oh   = issue_fire ? grant : '0;

    always_comb begin
        sel_issue = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (grant[i]) begin
                sel_issue.op = slot_q[i].op;
                sel_issue.a  = slot_q[i].opa.val;
                sel_issue.b  = slot_q[i].opb.val;
                sel_issue.c  = slot_q[i].opc;
                sel_issue.rd = slot_q[i].rd;
                sel_issue.id = slot_q[i].id;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i].valid && wb_hit) begin
                if (!slot_q[i].opa.rdy && (slot_q[i].opa.rs == wb_rd_i)) begin
                    slot_d[i].opa.rdy = 1'b1;
                    slot_d[i].opa.val = wb_data_i;
                end
                if (!slot_q[i].opb.rdy && (slot_q[i].opb.rs == wb_rd_i)) begin
                    slot_d[i].opb.rdy = 1'b1;
                    slot_d[i].opb.val = wb_data_i;
                end
            end
            if (issue_oh[i]) begin
                slot_d[i].valid = 1'b0;
            end
            if (alloc_oh[i]) begin
                slot_d[i] = new_slot;
            end
            if (flush_i) begin
                slot_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_d       = issue_q;
        if (flush_i) begin
            issue_valid_d = 1'b0;
        end else if (issue_fire) begin
            issue_valid_d = 1'b1;
            issue_d       = sel_issue;
        end else if (alu_ready_i) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_q       <= '{op: ADD, a: '0, b: '0, c: '0, rd: '0, id: '0};
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= slot_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
        end
    end

    assign alu_valid_o = issue_valid_q;
    assign alu_op_o    = issue_q.op;
    assign alu_a_o     = issue_q.a;
    assign alu_b_o     = issue_q.b;
    assign alu_c_o     = issue_q.c;
    assign alu_rd_o    = issue_q.rd;
    assign alu_id_o    = issue_q.id[TID_W-1:0];

    // Upper id bits have no sink; the fu tag is consumed only by the assertion below.
    logic unused_bits;
    assign unused_bits = ^{issue_q.id, dispatch_sbe_i.fu};

    dispatch_fu_alu: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dispatch_fire |-> (dispatch_sbe_i.fu == FU_ALU))
        else $error("non-ALU entry dispatched to the ALU issue queue");

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: stimulus pushes expected issues, a negedge monitor pops
// and compares every accepted issue, including the cycle it appears in.
module tb_alu_issue_queue;
    import tortoise_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TID_W = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_i = 1'b0;
    logic              dispatch_valid_i = 1'b0;
    logic              dispatch_ready_o;
    scoreboard_entry_t dispatch_sbe_i;
    logic [TID_W-1:0]  dispatch_id_i = '0;
    logic              op1_busy_i = 1'b0, op2_busy_i = 1'b0;
    data_t             op1_data_i = '0, op2_data_i = '0;
    logic              wb_valid_i = 1'b0;
    reg_t              wb_rd_i = '0;
    data_t             wb_data_i = '0;
    logic              alu_valid_o;
    logic              alu_ready_i = 1'b1;
    fu_op_t            alu_op_o;
    data_t             alu_a_o, alu_b_o, alu_c_o;
    reg_t              alu_rd_o;
    logic [TID_W-1:0]  alu_id_o;

    alu_issue_queue #(
        .DEPTH(DEPTH),
        .TID_W(TID_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .dispatch_valid_i(dispatch_valid_i),
        .dispatch_ready_o(dispatch_ready_o),
        .dispatch_sbe_i  (dispatch_sbe_i),
        .dispatch_id_i   (dispatch_id_i),
        .op1_busy_i      (op1_busy_i),
        .op2_busy_i      (op2_busy_i),
        .op1_data_i      (op1_data_i),
        .op2_data_i      (op2_data_i),
        .wb_valid_i      (wb_valid_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .alu_valid_o     (alu_valid_o),
        .alu_ready_i     (alu_ready_i),
        .alu_op_o        (alu_op_o),
        .alu_a_o         (alu_a_o),
        .alu_b_o         (alu_b_o),
        .alu_c_o         (alu_c_o),
        .alu_rd_o        (alu_rd_o),
        .alu_id_o        (alu_id_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        fu_op_t           op;
        data_t            a, b, c;
        reg_t             rd;
        logic [TID_W-1:0] id;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic scoreboard_entry_t mk(input fu_op_t op, input reg_t rs1, input reg_t rs2,
                                             input reg_t rd, input data_t imm,
                                             input logic use_imm, input data_t pc);
        scoreboard_entry_t s;
        s         = '0;
        s.fu      = FU_ALU;
        s.op      = op;
        s.rs1     = rs1;
        s.rs2     = rs2;
        s.rd      = rd;
        s.imm     = imm;
        s.use_imm = use_imm;
        s.pc      = pc;
        return s;
    endfunction

    task automatic expect_issue(input fu_op_t op, input data_t a, input data_t b, input data_t c,
                                input reg_t rd, input logic [TID_W-1:0] id, input int at);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.c = c; e.rd = rd; e.id = id; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic dispatch(input scoreboard_entry_t sbe, input logic [TID_W-1:0] id,
                            input logic b1, input logic b2, input data_t d1, input data_t d2);
        dispatch_valid_i = 1'b1;
        dispatch_sbe_i   = sbe;
        dispatch_id_i    = id;
        op1_busy_i       = b1;
        op2_busy_i       = b2;
        op1_data_i       = d1;
        op2_data_i       = d2;
        step(1);
        dispatch_valid_i = 1'b0;
        op1_busy_i       = 1'b0;
        op2_busy_i       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dispatch_ready"}, dispatch_ready_o, 1);
        check({tag, "_alu_valid"}, alu_valid_o, 0);
        check({tag, "_alu_op"}, alu_op_o, ADD);
        check({tag, "_alu_a"}, alu_a_o, 0);
        check({tag, "_alu_b"}, alu_b_o, 0);
        check({tag, "_alu_c"}, alu_c_o, 0);
        check({tag, "_alu_rd"}, alu_rd_o, 0);
        check({tag, "_alu_id"}, alu_id_o, 0);
    endtask

    // Monitor: every accepted issue must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni && alu_valid_o && alu_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_issue: got id %0d a %0h, expected no issue (cycle %0d)",
                         alu_id_o, alu_a_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_op", alu_op_o, mon_e.op);
                check("issue_a", alu_a_o, mon_e.a);
                check("issue_b", alu_b_o, mon_e.b);
                check("issue_c", alu_c_o, mon_e.c);
                check("issue_rd", alu_rd_o, mon_e.rd);
                check("issue_id", alu_id_o, mon_e.id);
                check("issue_cycle", cyc, mon_e.cyc);
            end
        end
    end

    int n;

    initial begin
        dispatch_sbe_i = '0;
        step(3);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        step(1);

        // ADDI x5,x0,7: x0 reads as zero regardless of register-file data.
        n = cyc;
        expect_issue(ADD, 32'h0, 32'h7, 32'h0, 5'd5, 3'd0, n + 2);
        dispatch(mk(ADD, 5'd0, 5'd0, 5'd5, 32'h7, 1'b1, 32'h100), 3'd0, 1'b0, 1'b0,
                 32'hBAD, 32'h0);
        step(4);

        // A waits on x3, younger B is ready and overtakes it.
        n = cyc;
        dispatch(mk(ADD, 5'd3, 5'd4, 5'd6, 32'h0, 1'b0, 32'h0), 3'd1, 1'b1, 1'b0,
                 32'hDEAD, 32'h22);
        expect_issue(SUB, 32'h5, 32'h3, 32'h0, 5'd7, 3'd2, n + 3);
        dispatch(mk(SUB, 5'd1, 5'd0, 5'd7, 32'h3, 1'b1, 32'h0), 3'd2, 1'b0, 1'b0,
                 32'h5, 32'h0);
        step(2);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'h10;
        expect_issue(ADD, 32'h10, 32'h22, 32'h0, 5'd6, 3'd1, n + 6);
        step(1);
        wb_valid_i = 1'b0;
        step(4);

        // Busy rs2 written back in the dispatch cycle is captured ready.
        n = cyc;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd9;
        wb_data_i  = 32'h99;
        expect_issue(XORL, 32'hF0, 32'h99, 32'h0, 5'd10, 3'd3, n + 2);
        dispatch(mk(XORL, 5'd2, 5'd9, 5'd10, 32'h0, 1'b0, 32'h0), 3'd3, 1'b0, 1'b1,
                 32'hF0, 32'hDEAD);
        wb_valid_i = 1'b0;
        step(4);

        // JALR carries pc+4 on operand c.
        n = cyc;
        expect_issue(JAL_R, 32'h2000, 32'h8, 32'h1004, 5'd1, 3'd6, n + 2);
        dispatch(mk(JAL_R, 5'd1, 5'd0, 5'd1, 32'h8, 1'b1, 32'h1000), 3'd6, 1'b0, 1'b0,
                 32'h2000, 32'h0);
        step(4);

        // Back-pressure: E0 parks in the issue register, E1..E4 fill every slot.
        alu_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dispatch(mk(ORL, reg_t'(k + 1), 5'd0, reg_t'(k + 1), data_t'(k), 1'b1, 32'h0),
                     TID_W'(k), 1'b0, 1'b0, 32'h100 + data_t'(k), 32'h0);
        end
        check("full_dispatch_ready", dispatch_ready_o, 0);
        repeat (3) begin
            check("stall_valid", alu_valid_o, 1);
            check("stall_a", alu_a_o, 32'h100);
            check("stall_id", alu_id_o, 0);
            step(1);
        end
        n = cyc;
        alu_ready_i      = 1'b1;
        dispatch_valid_i = 1'b1;
        dispatch_sbe_i   = mk(ADD, 5'd0, 5'd0, 5'd9, 32'h55, 1'b1, 32'h0);
        dispatch_id_i    = 3'd5;
        check("full_ready_while_freeing", dispatch_ready_o, 0);
        for (int k = 0; k < 5; k++) begin
            expect_issue(ORL, 32'h100 + data_t'(k), data_t'(k), 32'h0, reg_t'(k + 1),
                         TID_W'(k), n + k);
        end
        step(1);
        dispatch_valid_i = 1'b0;
        step(8);

        // Flush with three queued slots and a pending issue, plus a competing dispatch.
        alu_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dispatch(mk(ANDL, reg_t'(k + 1), 5'd0, 5'd12, data_t'(k), 1'b1, 32'h0),
                     TID_W'(k), 1'b0, 1'b0, 32'h200 + data_t'(k), 32'h0);
        end
        check("pre_flush_valid", alu_valid_o, 1);
        flush_i          = 1'b1;
        dispatch_valid_i = 1'b1;
        dispatch_sbe_i   = mk(ADD, 5'd0, 5'd0, 5'd13, 32'h77, 1'b1, 32'h0);
        dispatch_id_i    = 3'd7;
        step(1);
        flush_i          = 1'b0;
        dispatch_valid_i = 1'b0;
        check("post_flush_valid", alu_valid_o, 0);
        check("post_flush_ready", dispatch_ready_o, 1);
        alu_ready_i = 1'b1;
        step(8);
        check("post_flush_idle_ready", dispatch_ready_o, 1);

        // Reset mid-operation discards in-flight work.
        alu_ready_i = 1'b0;
        dispatch(mk(SLL, 5'd1, 5'd0, 5'd14, 32'h1, 1'b1, 32'h0), 3'd4, 1'b0, 1'b0,
                 32'h300, 32'h0);
        dispatch(mk(SRL, 5'd2, 5'd0, 5'd15, 32'h2, 1'b1, 32'h0), 3'd5, 1'b0, 1'b0,
                 32'h301, 32'h0);
        rst_ni = 1'b0;
        step(1);
        check_reset_outputs("mid_reset");
        rst_ni      = 1'b1;
        alu_ready_i = 1'b1;
        step(8);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
